// File: rtl/and_reg_arbiter.sv
// -----------------------------------------------------------------------------
// and_reg_arbiter
//
// Round-robin arbiter and sequencer in front of one shared gated-capture
// register (q <= a & b). NREQ requesters each present an operand pair and a
// req line. One requester at a time is granted; the AND of its operand pair
// is captured into the shared register. The result is then held, tagged
// with the winner's id, until the consumer acknowledges it.
//
// Transaction flow: IDLE -> CAPTURE (1 cycle, gnt high) -> HOLD -> IDLE.
// Minimum transaction length is 3 cycles. req rising in cycle 0 gives gnt
// in cycle 1 and q_valid in cycle 2. All outputs come straight from flops.
//
// Optional feature (macro AND_REG_TIMEOUT_EN):
//   When defined, HOLD is abandoned after TIMEOUT cycles without q_ack.
//   The release comes with a one-cycle timeout_err pulse. q_ack on the
//   expiry cycle wins and gives a normal release with no error. When the
//   macro is undefined, HOLD waits for q_ack forever, and neither the
//   timeout_err port nor the hold counter exists.
//
// Parameters:
//   NREQ     number of requesters (>= 2)
//   WIDTH    operand/result width in bits (WIDTH=1 is a single gated D-FF)
//   TIMEOUT  HOLD cycles before forced release (macro builds only, >= 1)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active low
//   req          in   [NREQ]        per-requester request, held until gnt seen
//   a, b         in   [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   gnt          out  [NREQ]        one-hot grant, high only during CAPTURE
//   q            out  [WIDTH]       captured a[id] & b[id], kept after release
//   q_valid      out                result valid (HOLD state)
//   q_id         out  [clog2(NREQ)] index of the requester that owns q
//   q_ack        in                 consumer accept, sampled only in HOLD
//   busy         out                state != IDLE
//   timeout_err  out                (macro only) one-cycle forced-release pulse
// -----------------------------------------------------------------------------
module and_reg_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 1,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   a,
   input  logic [NREQ*WIDTH-1:0]   b,
   output logic [NREQ-1:0]         gnt,
   output logic [WIDTH-1:0]        q,
   output logic                    q_valid,
   output logic [$clog2(NREQ)-1:0] q_id,
   input  logic                    q_ack,
   output logic                    busy
`ifdef AND_REG_TIMEOUT_EN
   ,
   output logic                    timeout_err
`endif
);

   localparam int IDW       = $clog2(NREQ);
   localparam bit PARAMS_OK = (NREQ >= 2) && (WIDTH >= 1) && (TIMEOUT >= 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   state_t           state_q;
   logic [NREQ-1:0]  gnt_q;
   logic [WIDTH-1:0] q_q;
   logic             q_valid_q;
   logic [IDW-1:0]   q_id_q;
   logic [IDW-1:0]   ptr_q;

`ifdef AND_REG_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    hold_cnt_q;
   logic             timeout_err_q;
`endif

   // --------------------------------------------------------------------------
   // Round-robin winner search: first requester at or after ptr, modulo NREQ.
   // The scan runs from the farthest position back to ptr so the last hit,
   // i.e. the closest one to ptr, is the one that sticks.
   // --------------------------------------------------------------------------
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  scan_pos;
   logic [NREQ-1:0] winner_oh;

   // NOTE: every variable assigned in always_comb gets a default on entry;
   // a path that skips the assignment would otherwise infer a latch.
   always_comb begin
      winner   = ptr_q;
      scan_pos = ptr_q;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_pos = IDW'((int'(ptr_q) + k) % NREQ);
         if (req[scan_pos]) begin
            winner = scan_pos;
         end
      end
      winner_oh         = '0;
      winner_oh[winner] = 1'b1;
   end

   // --------------------------------------------------------------------------
   // Operand selection for the current owner, and the rotated pointer.
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] sel_and;
   logic [IDW-1:0]   ptr_d;

   always_comb begin
      sel_and = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (int'(q_id_q) == i) begin
            sel_and = a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Explicit wrap keeps this correct for NREQ that is not a power of two.
   assign ptr_d = (q_id_q == IDW'(NREQ - 1)) ? '0 : q_id_q + 1'b1;

   // --------------------------------------------------------------------------
   // Sequencer. Reset discards any transaction in flight, including q.
   // --------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments only, so every
   // branch below reads the values from before this clock edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         gnt_q         <= '0;
         q_q           <= '0;
         q_valid_q     <= 1'b0;
         q_id_q        <= '0;
         ptr_q         <= '0;
`ifdef AND_REG_TIMEOUT_EN
         hold_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
`ifdef AND_REG_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               // q_ack is ignored here; only a request starts a transaction.
               if (|req) begin
                  gnt_q   <= winner_oh;
                  q_id_q  <= winner;
                  state_q <= S_CAPTURE;
               end
            end

            S_CAPTURE: begin
               // The grant lasts one cycle and the pointer moves on even if
               // the owner withdrew, so a withdrawing requester cannot block
               // the others.
               gnt_q <= '0;
               ptr_q <= ptr_d;
               if (req[q_id_q]) begin
                  q_q       <= sel_and;
                  q_valid_q <= 1'b1;
                  state_q   <= S_HOLD;
`ifdef AND_REG_TIMEOUT_EN
                  hold_cnt_q <= '0;
`endif
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_HOLD: begin
               if (q_ack) begin
                  q_valid_q <= 1'b0;
                  state_q   <= S_IDLE;
               end
`ifdef AND_REG_TIMEOUT_EN
               // hold_cnt_q counts completed HOLD cycles without ack; the
               // TIMEOUT-th such cycle forces the release.
               else if (hold_cnt_q == CW'(TIMEOUT - 1)) begin
                  q_valid_q     <= 1'b0;
                  state_q       <= S_IDLE;
                  timeout_err_q <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
`endif
            end

            default: begin
               gnt_q     <= '0;
               q_valid_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs: all taken from flops. busy depends only on the state register.
   // --------------------------------------------------------------------------
   assign gnt     = gnt_q;
   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign q_id    = q_id_q;
   assign busy    = (state_q != S_IDLE);
`ifdef AND_REG_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`endif

   // --------------------------------------------------------------------------
   // Structural invariants of the sequencer.
   // --------------------------------------------------------------------------
   a_params_ok : assert property (@(posedge clk) PARAMS_OK);

   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst)
      $onehot0(gnt_q));

   a_gnt_only_in_capture : assert property (@(posedge clk) disable iff (!rst)
      ((gnt_q != '0) == (state_q == S_CAPTURE)));

   a_valid_only_in_hold : assert property (@(posedge clk) disable iff (!rst)
      (q_valid_q == (state_q == S_HOLD)));

endmodule
